// File: rtl/line_pkg.sv
// Shared types and constants for the Bresenham line engine.
// Optional pixel clipping is enabled by defining LINE_CLIP_EN.
package line_pkg;

  localparam int XW_DEF = 10;
  localparam int YW_DEF = 9;
  localparam int ERR_W_DEF = ((XW_DEF > YW_DEF) ? XW_DEF : YW_DEF) + 2;

  typedef logic [XW_DEF-1:0]           coord_x_t;
  typedef logic [YW_DEF-1:0]           coord_y_t;
  typedef logic signed [ERR_W_DEF-1:0] err_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Two guard bits over the wider coordinate keep dx, dy and err free of overflow.
  function automatic int err_width(int xw, int yw);
    return ((xw > yw) ? xw : yw) + 2;
  endfunction

endpackage

// File: rtl/bresenham_line_engine_if.sv
// Request and pixel-stream handshakes of the line engine.
// master = upstream/downstream environment, slave = the engine.
interface bresenham_line_engine_if import line_pkg::*; #(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
);

  logic          req_valid;
  logic          req_ready;
  logic          req_color;
  logic [XW-1:0] x0;
  logic [XW-1:0] x1;
  logic [YW-1:0] y0;
  logic [YW-1:0] y1;

  logic          pix_valid;
  logic          pix_ready;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_color;
  logic          pix_last;

  modport master (
    output req_valid, req_color, x0, x1, y0, y1, pix_ready,
    input  req_ready, pix_valid, pix_x, pix_y, pix_color, pix_last
  );

  modport slave (
    input  req_valid, req_color, x0, x1, y0, y1, pix_ready,
    output req_ready, pix_valid, pix_x, pix_y, pix_color, pix_last
  );

endinterface

// File: rtl/line_octant_setup.sv
// Combinational octant setup: deltas, step directions and initial error term.
// sx_neg/sy_neg high stand for a step of -1, low for +1.
module line_octant_setup import line_pkg::*; #(
  parameter  int XW = XW_DEF,
  parameter  int YW = YW_DEF,
  localparam int W  = err_width(XW, YW)
) (
  input  logic [XW-1:0]       x0,
  input  logic [XW-1:0]       x1,
  input  logic [YW-1:0]       y0,
  input  logic [YW-1:0]       y1,
  output logic signed [W-1:0] dx,
  output logic signed [W-1:0] dy,
  output logic signed [W-1:0] err,
  output logic                sx_neg,
  output logic                sy_neg
);

  logic signed [W-1:0] x_diff;
  logic signed [W-1:0] y_diff;

  // NOTE: every output is assigned on every pass through this block, so no latch is inferred.
  always_comb begin
    x_diff = $signed(W'(x1)) - $signed(W'(x0));
    y_diff = $signed(W'(y1)) - $signed(W'(y0));
    sx_neg = x_diff[W-1];
    sy_neg = y_diff[W-1];
    dx     = sx_neg ? -x_diff : x_diff;
    dy     = sy_neg ? y_diff : -y_diff;
    err    = dx + dy;
  end

endmodule

// File: rtl/bresenham_line_engine.sv
// Bresenham line rasteriser: one request in, one pixel per cycle out.
// Define LINE_CLIP_EN to drop pixels outside H_RES x V_RES.
module bresenham_line_engine import line_pkg::*; #(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
`ifdef LINE_CLIP_EN
  ,
  parameter int H_RES = 640,
  parameter int V_RES = 480
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  bresenham_line_engine_if.slave  bus,
  output logic                    busy,
  output logic                    done
);

  localparam int W = err_width(XW, YW);

  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_SETUP = S_SETUP;
  localparam logic [1:0] ST_RUN   = S_RUN;
  localparam logic [1:0] ST_DONE  = S_DONE;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [XW-1:0]       x_q;
  logic [XW-1:0]       x1_q;
  logic [YW-1:0]       y_q;
  logic [YW-1:0]       y1_q;
  logic                color_q;
  logic signed [W-1:0] dx_q;
  logic signed [W-1:0] dy_q;
  logic signed [W-1:0] err_q;
  logic                sx_neg_q;
  logic                sy_neg_q;

  logic signed [W-1:0] dx_s;
  logic signed [W-1:0] dy_s;
  logic signed [W-1:0] err_s;
  logic                sx_neg_s;
  logic                sy_neg_s;

  logic signed [W:0]   e2;
  logic                step_x;
  logic                step_y;
  logic signed [W-1:0] err_nxt;
  logic [XW-1:0]       x_nxt;
  logic [YW-1:0]       y_nxt;
  logic                at_end;
  logic                run;
  logic                pix_show;
  logic                step_en;
  logic                last;

  // x_q/y_q already hold the start point while in S_SETUP.
  line_octant_setup #(.XW(XW), .YW(YW)) u_setup (
    .x0     (x_q),
    .x1     (x1_q),
    .y0     (y_q),
    .y1     (y1_q),
    .dx     (dx_s),
    .dy     (dy_s),
    .err    (err_s),
    .sx_neg (sx_neg_s),
    .sy_neg (sy_neg_s)
  );

  // Both axis decisions compare against the same e2, taken before either update.
  always_comb begin
    e2      = {err_q, 1'b0};
    step_x  = (e2 >= dy_q);
    step_y  = (e2 <= dx_q);
    err_nxt = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
    x_nxt   = !step_x ? x_q : (sx_neg_q ? x_q - 1'b1 : x_q + 1'b1);
    y_nxt   = !step_y ? y_q : (sy_neg_q ? y_q - 1'b1 : y_q + 1'b1);
    at_end  = (x_q == x1_q) && (y_q == y1_q);
    run     = (state_q == ST_RUN);
  end

`ifdef LINE_CLIP_EN
  logic in_range;
  logic next_in_range;

  // The in-range pixels of a monotone path form one contiguous run, so the last
  // emitted pixel is the one whose successor leaves the window (or the endpoint).
  always_comb begin
    in_range      = (int'(x_q) < H_RES) && (int'(y_q) < V_RES);
    next_in_range = (int'(x_nxt) < H_RES) && (int'(y_nxt) < V_RES);
    pix_show      = run && in_range;
    step_en       = run && (bus.pix_ready || !in_range);
    last          = in_range && (at_end || !next_in_range);
  end
`else
  always_comb begin
    pix_show = run;
    step_en  = run && bus.pix_ready;
    last     = at_end;
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.req_valid) state_d = ST_SETUP;
      ST_SETUP: state_d = ST_RUN;
      ST_RUN:   if (step_en && at_end) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= 1'b0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            x_q     <= bus.x0;
            y_q     <= bus.y0;
            x1_q    <= bus.x1;
            y1_q    <= bus.y1;
            color_q <= bus.req_color;
          end
        end
        ST_SETUP: begin
          dx_q     <= dx_s;
          dy_q     <= dy_s;
          err_q    <= err_s;
          sx_neg_q <= sx_neg_s;
          sy_neg_q <= sy_neg_s;
        end
        ST_RUN: begin
          if (step_en) begin
            err_q <= err_nxt;
            x_q   <= x_nxt;
            y_q   <= y_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign bus.pix_valid = pix_show;
  assign bus.pix_x     = x_q;
  assign bus.pix_y     = y_q;
  assign bus.pix_color = color_q;
  assign bus.pix_last  = pix_show && last;

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Directed self-checking bench for bresenham_line_engine (default and LINE_CLIP_EN builds).
module tb_bresenham_line_engine;
  import line_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic done;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bresenham_line_engine_if bus ();

  bresenham_line_engine dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(string tag, int ex, int ey, logic el);
    check(tag, 32'({bus.pix_valid, bus.pix_x, bus.pix_y, bus.pix_last}),
               32'({1'b1, coord_x_t'(ex), coord_y_t'(ey), el}));
  endtask

  task automatic ctrl(string tag, logic rr, logic b, logic d, logic pv);
    check(tag, 32'({bus.req_ready, busy, done, bus.pix_valid}), 32'({rr, b, d, pv}));
  endtask

  task automatic reset_state(string tag);
    check(tag, 32'({bus.req_ready, busy, done, bus.pix_valid, bus.pix_last,
                    bus.pix_color, bus.pix_x, bus.pix_y}),
               32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 9'd0}));
  endtask

  // Returns one cycle after the accept edge (engine in setup), inputs scrambled.
  task automatic send(string tag, int ax0, int ay0, int ax1, int ay1, logic col);
    bus.req_valid = 1'b1;
    bus.x0        = coord_x_t'(ax0);
    bus.y0        = coord_y_t'(ay0);
    bus.x1        = coord_x_t'(ax1);
    bus.y1        = coord_y_t'(ay1);
    bus.req_color = col;
    for (int i = 0; i < 20 && !bus.req_ready; i++) tick();
    check({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.x0        = '1;
    bus.y0        = '1;
    bus.x1        = '1;
    bus.y1        = '1;
    bus.req_color = ~col;
    ctrl({tag, "_setup"}, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_color = 1'b0;
    bus.x0        = '0;
    bus.y0        = '0;
    bus.x1        = '0;
    bus.y1        = '0;
    bus.pix_ready = 1'b1;
    tick();
    tick();
    reset_state("reset");
    rst_n = 1'b1;
    tick();

    // Horizontal line
    send("t1", 0, 0, 3, 0, 1'b1);
    tick();
    check("t1_color", 32'(bus.pix_color), 32'd1);
    pix("t1_p0", 0, 0, 1'b0); tick();
    pix("t1_p1", 1, 0, 1'b0); tick();
    pix("t1_p2", 2, 0, 1'b0); tick();
    pix("t1_p3", 3, 0, 1'b1); tick();
    ctrl("t1_done", 1'b0, 1'b1, 1'b1, 1'b0); tick();
    ctrl("t1_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Steep reverse line with a 3-cycle stall at (4,3)
    send("t2", 5, 5, 3, 0, 1'b0);
    tick();
    pix("t2_p0", 5, 5, 1'b0); tick();
    pix("t2_p1", 5, 4, 1'b0); tick();
    pix("t2_p2", 4, 3, 1'b0);
    bus.pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      pix("t3_hold", 4, 3, 1'b0);
    end
    check("t3_color", 32'(bus.pix_color), 32'd0);
    bus.pix_ready = 1'b1;
    tick();
    pix("t2_p3", 4, 2, 1'b0); tick();
    pix("t2_p4", 3, 1, 1'b0); tick();
    pix("t2_p5", 3, 0, 1'b1); tick();
    ctrl("t2_done", 1'b0, 1'b1, 1'b1, 1'b0); tick();
    ctrl("t2_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Single point; a request held during the line must be ignored
    send("t4", 7, 9, 7, 9, 1'b1);
    bus.req_valid = 1'b1;
    bus.x0 = 10'd100; bus.y0 = 9'd100; bus.x1 = 10'd101; bus.y1 = 9'd101;
    tick();
    pix("t4_p0", 7, 9, 1'b1); tick();
    ctrl("t4_done", 1'b0, 1'b1, 1'b1, 1'b0); tick();
    ctrl("t4_ready", 1'b1, 1'b0, 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    tick();
    ctrl("t4_noqueue", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after the second pixel of the steep line
    send("t5", 5, 5, 3, 0, 1'b0);
    tick();
    pix("t5_p0", 5, 5, 1'b0); tick();
    pix("t5_p1", 5, 4, 1'b0); tick();
    rst_n = 1'b0;
    #1;
    reset_state("t5_rst");
    tick();
    rst_n = 1'b1;
    tick();
    ctrl("t5_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    send("t5b", 1, 1, 2, 2, 1'b1);
    tick();
    pix("t5b_p0", 1, 1, 1'b0); tick();
    pix("t5b_p1", 2, 2, 1'b1); tick();
    ctrl("t5b_done", 1'b0, 1'b1, 1'b1, 1'b0); tick();
    ctrl("t5b_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Line crossing the right edge of the visible area
    send("t6", 638, 0, 641, 0, 1'b1);
    tick();
`ifdef LINE_CLIP_EN
    pix("t6_p0", 638, 0, 1'b0); tick();
    pix("t6_p1", 639, 0, 1'b1); tick();
    ctrl("t6_clip0", 1'b0, 1'b1, 1'b0, 1'b0); tick();
    ctrl("t6_clip1", 1'b0, 1'b1, 1'b0, 1'b0); tick();
`else
    pix("t6_p0", 638, 0, 1'b0); tick();
    pix("t6_p1", 639, 0, 1'b0); tick();
    pix("t6_p2", 640, 0, 1'b0); tick();
    pix("t6_p3", 641, 0, 1'b1); tick();
`endif
    ctrl("t6_done", 1'b0, 1'b1, 1'b1, 1'b0); tick();
    ctrl("t6_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
